pipeline_ctrl: RTL

- Hazard and sequencing controller for the swt16 core pipeline (IF → ID → EX → MEM/WB).
- Tracks in-flight register writes, detects load-use hazards, and drives stall, flush and forwarding selects for the decoder and IALU operand muxes.
- Redirects the PC on taken jumps and counts stall cycles for performance monitoring.

---
 rtl/pipeline_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/sequencing controller for the swt16 pipeline.
// Tracks EX/MEM register writes, drives load-use stall, flush, PC redirect and forwarding selects.
`default_nettype none

module pipeline_ctrl #(
   parameter int REG_IDX_WIDTH  = 4,
   parameter int PC_WIDTH       = 12,
   parameter int FLUSH_CYCLES   = 2,
   parameter int PERF_CNT_WIDTH = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      id_valid,
   input  logic [REG_IDX_WIDTH-1:0]  id_src1_reg_idx,
   input  logic [REG_IDX_WIDTH-1:0]  id_src2_reg_idx,
   input  logic                      id_uses_src1,
   input  logic                      id_uses_src2,
   input  logic [REG_IDX_WIDTH-1:0]  id_res_reg_idx,
   input  logic                      id_act_write_res_to_reg,
   input  logic                      id_act_load_dmem,
   input  logic                      ex_act_jump,
   input  logic [PC_WIDTH-1:0]       ex_jump_target,
   output logic                      out_stall,
   output logic                      out_flush,
   output logic                      out_pc_sel_jump,
   output logic [PC_WIDTH-1:0]       out_jump_target,
   output logic [1:0]                out_fwd_src1_sel,
   output logic [1:0]                out_fwd_src2_sel,
   output logic [PERF_CNT_WIDTH-1:0] out_stall_count
);

   localparam int          FC_W      = 3;
   localparam logic [FC_W-1:0] FC_RELOAD = FC_W'(FLUSH_CYCLES - 1);
   localparam logic [1:0]  SEL_RF    = 2'd0;
   localparam logic [1:0]  SEL_EX    = 2'd1;
   localparam logic [1:0]  SEL_MEM   = 2'd2;

   logic                      ex_vld;
   logic [REG_IDX_WIDTH-1:0]  ex_idx;
   logic                      ex_is_load;
   logic                      mem_vld;
   logic [REG_IDX_WIDTH-1:0]  mem_idx;
   logic [FC_W-1:0]           flush_cnt;
   logic [PERF_CNT_WIDTH-1:0] stall_cnt;

   logic       ex_hit1, ex_hit2, mem_hit1, mem_hit2;
   logic       flush_raw, stall_raw;
   logic [1:0] fwd1_raw, fwd2_raw;

   always_comb begin
      ex_hit1  = id_uses_src1 & ex_vld  & (id_src1_reg_idx == ex_idx);
      ex_hit2  = id_uses_src2 & ex_vld  & (id_src2_reg_idx == ex_idx);
      mem_hit1 = id_uses_src1 & mem_vld & (id_src1_reg_idx == mem_idx);
      mem_hit2 = id_uses_src2 & mem_vld & (id_src2_reg_idx == mem_idx);

      flush_raw = ex_act_jump | (flush_cnt != '0);
      stall_raw = id_valid & ~flush_raw & ex_is_load & (ex_hit1 | ex_hit2);

      // A load in EX cannot forward; its operand falls through to the MEM check.
      fwd1_raw = SEL_RF;
      if (ex_hit1 & ~ex_is_load) fwd1_raw = SEL_EX;
      else if (mem_hit1)         fwd1_raw = SEL_MEM;

      fwd2_raw = SEL_RF;
      if (ex_hit2 & ~ex_is_load) fwd2_raw = SEL_EX;
      else if (mem_hit2)         fwd2_raw = SEL_MEM;
   end

   // Combinational outputs are forced to zero for as long as reset is held.
   always_comb begin
      out_stall        = reset & stall_raw;
      out_flush        = reset & flush_raw;
      out_pc_sel_jump  = reset & ex_act_jump;
      out_jump_target  = (reset & ex_act_jump) ? ex_jump_target : '0;
      out_fwd_src1_sel = reset ? fwd1_raw : SEL_RF;
      out_fwd_src2_sel = reset ? fwd2_raw : SEL_RF;
      out_stall_count  = stall_cnt;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ex_vld     <= 1'b0;
         ex_idx     <= '0;
         ex_is_load <= 1'b0;
         mem_vld    <= 1'b0;
         mem_idx    <= '0;
         flush_cnt  <= '0;
         stall_cnt  <= '0;
      end else begin
         mem_vld <= ex_vld;
         mem_idx <= ex_idx;

         if (stall_raw | flush_raw) begin
            ex_vld     <= 1'b0;
            ex_is_load <= 1'b0;
         end else begin
            ex_vld     <= id_valid & id_act_write_res_to_reg;
            ex_is_load <= id_valid & id_act_write_res_to_reg & id_act_load_dmem;
         end
         ex_idx <= id_res_reg_idx;

         if (ex_act_jump)            flush_cnt <= FC_RELOAD;
         else if (flush_cnt != '0)   flush_cnt <= flush_cnt - 1'b1;

         if (stall_raw && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

`default_nettype wire
